// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule front end: packs a 512-bit block from IN_W-bit beats,
// then streams W_0..W_{ROUNDS-1} to the round core over a valid/ready port.
module sha256_msg_sched #(
  parameter int IN_W   = 8,
  parameter int ROUNDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     w_data,
  output logic [5:0]      w_idx,
  output logic            w_valid,
  input  logic            w_ready,
  output logic            busy,
  output logic            dbg_state
);

  localparam int         BEATS     = 32 / IN_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);

  typedef enum logic {ST_LOAD = 1'b0, ST_EMIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_win [16];
  logic [31:0] r_pack;
  logic [1:0]  r_beat;
  logic [3:0]  r_word;
  logic [5:0]  r_idx;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_word_done;
  logic        w_block_done;
  logic        w_shift_en;
  logic [31:0] w_packed;
  logic [31:0] w_new;
  logic [31:0] w_shift_in;

  function automatic logic [31:0] f_sigma0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sigma1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Handshake: a beat/word transfers on a rising edge where valid and ready are both high.
  assign in_ready  = (r_state == ST_LOAD);
  assign w_valid   = (r_state == ST_EMIT);
  assign w_data    = r_win[0];
  assign w_idx     = r_idx;
  assign busy      = (r_state == ST_EMIT) | (r_beat != 2'd0) | (r_word != 4'd0);
  assign dbg_state = r_state;

  assign w_in_fire    = in_valid & in_ready;
  assign w_out_fire   = w_valid & w_ready;
  assign w_word_done  = w_in_fire & (r_beat == LAST_BEAT);
  assign w_block_done = w_word_done & (r_word == 4'd15);

  // Earlier beats move up by one beat width; the new beat lands in the low bits.
  assign w_packed   = (r_pack << IN_W) | 32'(in_data);
  assign w_new      = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];
  assign w_shift_en = (w_word_done | w_out_fire) & ~abort;
  assign w_shift_in = in_ready ? w_packed : w_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (w_block_done) w_state_nxt = ST_EMIT;
        ST_EMIT: if (w_out_fire && (r_idx == LAST_IDX)) w_state_nxt = ST_LOAD;
        default: w_state_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
      r_pack <= 32'd0;
      r_beat <= 2'd0;
      r_word <= 4'd0;
      r_idx  <= 6'd0;
    end else if (abort) begin
      r_beat <= 2'd0;
      r_word <= 4'd0;
      r_idx  <= 6'd0;
    end else begin
      if (w_in_fire) begin
        r_pack <= w_packed;
        r_beat <= (r_beat == LAST_BEAT) ? 2'd0 : r_beat + 2'd1;
        // Word counter wraps 15 -> 0 as the block completes.
        if (w_word_done) r_word <= r_word + 4'd1;
      end
      if (w_out_fire) r_idx <= (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
      if (w_shift_en) begin
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_shift_in;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: byte-wide 64-round instance plus a
// word-wide 16-round instance, directed blocks with hand-computed words.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        abort8, in_valid8, in_ready8, w_valid8, w_ready8, busy8, dbg8;
  logic [7:0]  in_data8;
  logic [31:0] w_data8;
  logic [5:0]  w_idx8;

  logic        abort32, in_valid32, in_ready32, w_valid32, w_ready32, busy32, dbg32;
  logic [31:0] in_data32;
  logic [31:0] w_data32;
  logic [5:0]  w_idx32;

  int n_vec = 0;
  int n_err = 0;

  logic [37:0] exp8_q[$];
  logic [37:0] exp32_q[$];
  logic [31:0] blk [16];
  logic [31:0] ref_w [64];

  sha256_msg_sched #(.IN_W(8), .ROUNDS(64)) u_dut8 (
    .clk(clk), .rst(rst), .abort(abort8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .w_data(w_data8), .w_idx(w_idx8), .w_valid(w_valid8), .w_ready(w_ready8),
    .busy(busy8), .dbg_state(dbg8)
  );

  sha256_msg_sched #(.IN_W(32), .ROUNDS(16)) u_dut32 (
    .clk(clk), .rst(rst), .abort(abort32),
    .in_data(in_data32), .in_valid(in_valid32), .in_ready(in_ready32),
    .w_data(w_data32), .w_idx(w_idx32), .w_valid(w_valid32), .w_ready(w_ready32),
    .busy(busy32), .dbg_state(dbg32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // kind 0: "abc" padded block; kind 1: arbitrary byte pattern
  function automatic logic [7:0] byte_of(input int kind, input int i);
    if (kind == 1) return 8'(i * 37 + 11);
    case (i)
      0:  return 8'h61;
      1:  return 8'h62;
      2:  return 8'h63;
      3:  return 8'h80;
      63: return 8'h18;
      default: return 8'h00;
    endcase
  endfunction

  // Hand-computed schedule words of the "abc" block, t = 0..17
  function automatic logic [31:0] abc_w(input int t);
    case (t)
      0, 16:   return 32'h61626380;
      15:      return 32'h00000018;
      17:      return 32'h000F0000;
      default: return 32'h00000000;
    endcase
  endfunction

  task automatic set_block(input int kind);
    for (int w = 0; w < 16; w++)
      blk[w] = {byte_of(kind, 4*w), byte_of(kind, 4*w+1), byte_of(kind, 4*w+2), byte_of(kind, 4*w+3)};
    for (int t = 0; t < 64; t++)
      ref_w[t] = (t < 16) ? blk[t] : s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic push_exp8(input int kind);
    for (int t = 0; t < 64; t++)
      exp8_q.push_back({6'(t), (kind == 0 && t < 18) ? abc_w(t) : ref_w[t]});
  endtask

  task automatic push_exp32();
    for (int t = 0; t < 16; t++) exp32_q.push_back({6'(t), blk[t]});
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && w_valid8 && w_ready8 && !abort8) begin
      if (exp8_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut8 unexpected word: got idx %0d data %h, none expected", w_idx8, w_data8);
      end else begin
        check("dut8 word {idx,data}", {26'd0, w_idx8, w_data8}, {26'd0, exp8_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_valid32 && w_ready32 && !abort32) begin
      if (exp32_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut32 unexpected word: got idx %0d data %h, none expected", w_idx32, w_data32);
      end else begin
        check("dut32 word {idx,data}", {26'd0, w_idx32, w_data32}, {26'd0, exp32_q.pop_front()});
      end
    end
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic send8(input logic [7:0] b, input bit bubble);
    int guard;
    guard = 0;
    if (bubble) begin
      in_valid8 = 1'b0;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b1;
    in_data8  = b;
    while (!in_ready8 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) fail_now("dut8 in_ready wait");
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic load8(input int kind, input bit bubbles, input int nbytes);
    for (int i = 0; i < nbytes; i++) send8(byte_of(kind, i), bubbles && (i % 2 == 1));
  endtask

  task automatic drain8(input int stall_at, input bit hold_valid, input int abort_at);
    int stall, guard;
    bit done;
    stall = 0; guard = 0; done = 1'b0;
    in_valid8 = hold_valid;
    in_data8  = 8'hA5;
    while (!done && guard < 300) begin
      w_ready8 = 1'b1;
      if (w_valid8 && abort_at >= 0 && int'(w_idx8) == abort_at) begin
        abort8 = 1'b1;
        done   = 1'b1;
      end else if (w_valid8 && stall_at >= 0 && int'(w_idx8) == stall_at && stall < 5) begin
        w_ready8 = 1'b0;
        stall++;
        check("stall w_idx", 64'(w_idx8), 64'(stall_at));
        check("stall w_data", 64'(w_data8), 64'(ref_w[stall_at]));
      end else if (w_valid8 && w_idx8 == 6'd63) begin
        done = 1'b1;
      end
      if (hold_valid) check("in_ready during EMIT", 64'(in_ready8), 64'd0);
      @(posedge clk); #1;
      guard++;
    end
    abort8 = 1'b0; w_ready8 = 1'b0; in_valid8 = 1'b0;
    if (!done) fail_now("dut8 drain");
    check("in_ready after block", 64'(in_ready8), 64'd1);
    check("w_valid after block", 64'(w_valid8), 64'd0);
    check("busy after block", 64'(busy8), 64'd0);
    check("state after block", 64'(dbg8), 64'd0);
  endtask

  task automatic load32();
    int guard;
    for (int w = 0; w < 16; w++) begin
      guard = 0;
      in_valid32 = 1'b1;
      in_data32  = blk[w];
      while (!in_ready32 && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) fail_now("dut32 in_ready wait");
      @(posedge clk); #1;
      in_valid32 = 1'b0;
    end
  endtask

  task automatic drain32();
    int guard;
    bit done;
    guard = 0; done = 1'b0;
    w_ready32 = 1'b1;
    while (!done && guard < 100) begin
      if (w_valid32 && w_idx32 == 6'd15) done = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    w_ready32 = 1'b0;
    if (!done) fail_now("dut32 drain");
    check("dut32 in_ready after block", 64'(in_ready32), 64'd1);
    check("dut32 w_valid after block", 64'(w_valid32), 64'd0);
    check("dut32 busy after block", 64'(busy32), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    abort8 = 0; in_valid8 = 0; w_ready8 = 0; in_data8 = 0;
    abort32 = 0; in_valid32 = 0; w_ready32 = 0; in_data32 = 0;
    #1;
    check("reset in_ready", 64'(in_ready8), 64'd1);
    check("reset w_valid", 64'(w_valid8), 64'd0);
    check("reset w_data", 64'(w_data8), 64'd0);
    check("reset w_idx", 64'(w_idx8), 64'd0);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset dut32 in_ready", 64'(in_ready32), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // "abc" block, no bubbles, no stall
    set_block(0);
    load8(0, 1'b0, 64);
    push_exp8(0);
    drain8(-1, 1'b0, -1);

    // same block with input bubbles, backpressure at idx 20, in_valid held in EMIT
    load8(0, 1'b1, 64);
    push_exp8(0);
    drain8(20, 1'b1, -1);

    // pattern block
    set_block(1);
    load8(1, 1'b0, 64);
    push_exp8(1);
    drain8(-1, 1'b0, -1);

    // abort after 10 bytes, then a fresh "abc" block
    set_block(0);
    load8(0, 1'b0, 10);
    check("busy mid-load", 64'(busy8), 64'd1);
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    check("busy after abort", 64'(busy8), 64'd0);
    check("in_ready after abort", 64'(in_ready8), 64'd1);
    load8(0, 1'b0, 64);
    push_exp8(0);
    drain8(-1, 1'b0, -1);

    // abort at idx 30 together with w_ready
    load8(0, 1'b0, 64);
    push_exp8(0);
    drain8(-1, 1'b0, 30);
    check("next expected idx at abort", 64'(exp8_q.size() > 0 ? exp8_q[0][37:32] : 6'h3F), 64'd30);
    exp8_q.delete();
    w_ready8 = 1'b1;
    repeat (3) begin
      check("w_valid after abort", 64'(w_valid8), 64'd0);
      @(posedge clk); #1;
    end
    w_ready8 = 1'b0;

    // word-wide 16-round instance
    set_block(0);
    load32();
    push_exp32();
    drain32();
    set_block(1);
    load32();
    push_exp32();
    drain32();

    // asynchronous reset mid-EMIT, between clock edges
    set_block(0);
    load8(0, 1'b0, 64);
    push_exp8(0);
    w_ready8 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    w_ready8 = 1'b0;
    check("idx before async reset", 64'(w_idx8), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async reset in_ready", 64'(in_ready8), 64'd1);
    check("async reset w_valid", 64'(w_valid8), 64'd0);
    check("async reset w_idx", 64'(w_idx8), 64'd0);
    check("async reset busy", 64'(busy8), 64'd0);
    exp8_q.delete();
    #3;
    rst = 1'b0;
    @(posedge clk); #1;

    check("dut8 queue drained", 64'(exp8_q.size()), 64'd0);
    check("dut32 queue drained", 64'(exp32_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
